disp_hex_mux: RTL and testbench
===============================

Name: disp_hex_mux

Overview:
- Downstream consumer of the level/debounced edge counters.
- Shows two 8-bit values (raw count, debounced count) as four hex digits on a time-multiplexed common-anode 7-segment display.
- Inputs are snapshotted once per refresh frame, so a digit never tears mid-frame.
- Anode and segment outputs are registered and drive the board pins directly.

Parameters:
- N_REFRESH, 18, refresh counter width. Each digit is lit for 2^(N_REFRESH-2) cycles. Legal range is 2 or more.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, synchronous, active-low (0 = reset)
- i_val_hi  in  8  value for digits 3..2 (raw count)
- i_val_lo  in  8  value for digits 1..0 (debounced count)
- i_dp  in  4  decimal point enable per digit, 1 = lit; bit k is digit k
- o_an  out  4  digit anodes, active-low; bit k is digit k
- o_sseg  out  8  segments, active-low, ordered {dp,g,f,e,d,c,b,a}

Behaviour:
- Reset: applied when i_rst=0 at a rising edge of i_clk.
  - r_q=0; shadow regs (hi, lo, dp) = 0.
  - o_an=4'b1111; o_sseg=8'hFF.
  - Reset mid-frame: same values at the next edge; the frame restarts.
- Refresh counter: r_q, N_REFRESH bits, increments every cycle and wraps from 2^N-1 to 0. Digit select sel=r_q[N-1:N-2].
- Snapshot: at the edge where r_q==2^N-1, shadow <= {i_val_hi, i_val_lo, i_dp}. Input changes at any other time have no visible effect until the next frame.
- Outputs: registered. At each edge, o_an/o_sseg are loaded from the pre-edge sel and pre-edge shadow.
  - Latency: 1 cycle from sel change to pins.
  - The frame that starts when r_q becomes 0 displays only the newest snapshot.
- Digit mapping:
  - sel 0 = lo[3:0]
  - sel 1 = lo[7:4]
  - sel 2 = hi[3:0]
  - sel 3 = hi[7:4]
- Anodes: o_an = ~(4'b0001 << sel). Exactly one anode is low outside reset.
- Decode, active-low [6:0]:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
  - o_sseg[7] = ~shadow_dp[sel].
- First frame after reset displays shadow=0. Every digit shows "0" (o_sseg=8'hC0), with dp off.
- N_REFRESH=2: each digit is lit for exactly 1 cycle; the frame is 4 cycles.

Optional Feature:
- Macro DISP_LZ_BLANK_EN: leading-zero blanking per byte.
- Defined:
  - If shadow hi[7:4]==0 and slot is sel 3, then o_an=4'b1111 and o_sseg=8'hFF for that slot.
  - Same rule for lo[7:4] at sel 1.
  - Low nibbles are never blanked.
  - The blanking decision uses shadow values, so it is frame-consistent.
- Undefined: every digit is always shown, including leading zeros.

Decomposition:
- Package disp_pkg holds:
  - localparam SSEG_BLANK=8'hFF
  - SSEG_DIGITS=4
  - typedef logic [3:0] hex_t
  - typedef logic [7:0] sseg_t
- Sub-module hex_to_sseg (combinational): hex_t in, 7-bit active-low segments out, table as above. Top level adds dp and the register stage.

Test Plan (N_REFRESH=4: 4 cycles per digit, 16-cycle frame):
- Reset: hold i_rst=0 for 3 edges, then release -> o_an=1111 and o_sseg=FF during reset. On the first post-reset edge, o_an=1110 and o_sseg=C0.
- Snapshot: hi=8'h3A, lo=8'h5F, dp=4'b0100 applied mid-frame 1. Frame 2 shows, in order:
  - digit0 o_sseg=8E
  - digit1 92
  - digit2 08 (dp lit)
  - digit3 B0
  - Frame 1 stays all C0.
- Anode walk: over 16 cycles, o_an is 1110, 1101, 1011, 0111 for 4 cycles each, then repeats.
- Tearing: change lo from 8'h11 to 8'h22 when r_q=6 -> o_sseg for digits 0/1 stays F9 until the frame wrap, then becomes A4.
- Reset mid-frame: i_rst=0 at r_q=9 for 1 edge -> o_an=1111 and o_sseg=FF. Next edge shows digit0 of zero shadow (C0).
- DISP_LZ_BLANK_EN: hi=8'h07, lo=8'h00 -> slot3 o_an=1111/o_sseg=FF; slot1 blanked; slot2=F8; slot0=C0. Without the macro, slot3 and slot1 show C0.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed hex display.
// Contents:
//   SSEG_DIGITS - number of multiplexed digits
//   hex_t       - one hex nibble
//   sseg_t      - active-low segment byte {dp,g,f,e,d,c,b,a}
//   SSEG_BLANK  - segment byte with every segment off
//   digit_anode - active-low anode pattern for a digit select
package disp_pkg;

  localparam int SSEG_DIGITS = 4;

  typedef logic [3:0] hex_t;
  typedef logic [7:0] sseg_t;

  localparam sseg_t SSEG_BLANK = 8'hFF;

  // Active-low one-cold anode for the selected digit.
  function automatic logic [SSEG_DIGITS-1:0] digit_anode(input logic [1:0] sel);
    digit_anode = ~(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/disp_hex_mux_hex_to_sseg.sv
// Combinational hex nibble to 7-segment decoder.
// Ports:
//   hex_i  - nibble to show
//   seg_o  - active-low segments {g,f,e,d,c,b,a}; the caller adds dp
module hex_to_sseg
  import disp_pkg::*;
(
  input  hex_t       hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    unique case (hex_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/disp_hex_mux.sv
// Four-digit time-multiplexed common-anode hex display driver.
// Shows i_val_hi on digits 3..2 and i_val_lo on digits 1..0. Inputs are
// captured once per refresh frame (on the last cycle of the frame) so a
// frame never mixes old and new values. Anodes and segments are registered
// and drive the pins directly.
// Ports:
//   i_clk     - system clock
//   i_rst     - synchronous reset, active-low
//   i_val_hi  - value for digits 3..2
//   i_val_lo  - value for digits 1..0
//   i_dp      - decimal point enable per digit, 1 = lit
//   o_an      - digit anodes, active-low, bit k is digit k
//   o_sseg    - segments, active-low, {dp,g,f,e,d,c,b,a}
// Parameter:
//   N_REFRESH - refresh counter width (>= 2); each digit is lit for
//               2^(N_REFRESH-2) cycles
// Build option:
//   DISP_LZ_BLANK_EN - when defined, a zero high nibble of either byte is
//                      blanked (anode off, segments off) in its slot
module disp_hex_mux
  import disp_pkg::*;
#(
  parameter int N_REFRESH = 18
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_val_hi,
  input  logic [7:0] i_val_lo,
  input  logic [3:0] i_dp,
  output logic [3:0] o_an,
  output logic [7:0] o_sseg
);

  logic [N_REFRESH-1:0] r_q, r_d;
  logic [7:0]           hi_q, hi_d;
  logic [7:0]           lo_q, lo_d;
  logic [3:0]           dp_q, dp_d;
  logic [3:0]           an_q, an_d;
  sseg_t                sseg_q, sseg_d;

  logic [1:0] sel;
  logic       frame_end;
  hex_t       nibble;
  logic [6:0] seg_raw;

  assign sel       = r_q[N_REFRESH-1 -: 2];
  assign frame_end = &r_q;

  always_comb begin
    nibble = lo_q[3:0];
    unique case (sel)
      2'd0: nibble = lo_q[3:0];
      2'd1: nibble = lo_q[7:4];
      2'd2: nibble = hi_q[3:0];
      2'd3: nibble = hi_q[7:4];
      default: nibble = lo_q[3:0];
    endcase
  end

  hex_to_sseg u_dec (
    .hex_i (nibble),
    .seg_o (seg_raw)
  );

  always_comb begin
    r_d    = r_q + N_REFRESH'(1);
    hi_d   = hi_q;
    lo_d   = lo_q;
    dp_d   = dp_q;
    // Snapshot on the last cycle so the frame starting at r_q==0 uses it.
    if (frame_end) begin
      hi_d = i_val_hi;
      lo_d = i_val_lo;
      dp_d = i_dp;
    end

    an_d   = digit_anode(sel);
    sseg_d = {~dp_q[sel], seg_raw};
`ifdef DISP_LZ_BLANK_EN
    if ((sel == 2'd3 && hi_q[7:4] == 4'h0) ||
        (sel == 2'd1 && lo_q[7:4] == 4'h0)) begin
      an_d   = 4'hF;
      sseg_d = SSEG_BLANK;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      dp_q   <= '0;
      an_q   <= 4'hF;
      sseg_q <= SSEG_BLANK;
    end else begin
      r_q    <= r_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
    end
  end

  assign o_an   = an_q;
  assign o_sseg = sseg_q;

endmodule

// File: tb/tb_disp_hex_mux.sv
module tb_disp_hex_mux;

  localparam int NR    = 4;
  localparam int FRAME = 1 << NR;
  localparam int SLOT  = FRAME / 4;

  logic       clk;
  logic       rst;
  logic [7:0] val_hi;
  logic [7:0] val_lo;
  logic [3:0] dp;
  logic [3:0] an;
  logic [7:0] sseg;

  int checks = 0;
  int errors = 0;

  disp_hex_mux #(.N_REFRESH(NR)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_val_hi (val_hi),
    .i_val_lo (val_lo),
    .i_dp     (dp),
    .o_an     (an),
    .o_sseg   (sseg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Digit glyphs (active-low g..a) straight from the display table.
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // What the pins show for frame position pos given a snapshot: {an, sseg}.
  function automatic logic [11:0] model_out(input int pos, input logic [7:0] h,
                                            input logic [7:0] l, input logic [3:0] d);
    int         k;
    logic [15:0] v;
    logic [3:0]  nib;
    logic [3:0]  a;
    logic [7:0]  s;
    k   = pos / SLOT;
    v   = {h, l};
    nib = 4'((v >> (4 * k)) & 16'hF);
    a   = 4'(4'hF ^ (1 << k));
    s   = {~d[k], glyph[nib]};
`ifdef DISP_LZ_BLANK_EN
    if ((k == 1 || k == 3) && nib == 4'h0) begin
      a = 4'hF;
      s = 8'hFF;
    end
`endif
    return {a, s};
  endfunction

  // Model state: frame position (mirrors what the counter must hold after
  // each edge), the snapshot, and the expected pins.
  int         m_cnt   = 0;
  logic [7:0] m_hi    = 8'h00;
  logic [7:0] m_lo    = 8'h00;
  logic [3:0] m_dp    = 4'h0;
  logic [3:0] m_an    = 4'hF;
  logic [7:0] m_sseg  = 8'hFF;
  logic       m_valid = 1'b0;

  always @(posedge clk) begin
    m_valid <= 1'b1;
    if (!rst) begin
      m_cnt  <= 0;
      m_hi   <= 8'h00;
      m_lo   <= 8'h00;
      m_dp   <= 4'h0;
      m_an   <= 4'hF;
      m_sseg <= 8'hFF;
    end else begin
      {m_an, m_sseg} <= model_out(m_cnt, m_hi, m_lo, m_dp);
      if (m_cnt == FRAME - 1) begin
        m_hi <= val_hi;
        m_lo <= val_lo;
        m_dp <= val_dp_now();
      end
      m_cnt <= (m_cnt + 1) % FRAME;
    end
  end

  function automatic logic [3:0] val_dp_now();
    return dp;
  endfunction

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      checks++;
      if (an !== m_an || sseg !== m_sseg) begin
        errors++;
        $display("FAIL model t=%0t pos=%0d an=%b sseg=%h required an=%b sseg=%h",
                 $time, m_cnt, an, sseg, m_an, m_sseg);
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] a_exp, input logic [7:0] s_exp);
    checks++;
    if (an !== a_exp || sseg !== s_exp) begin
      errors++;
      $display("FAIL %s an=%b sseg=%h required an=%b sseg=%h", name, an, sseg, a_exp, s_exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance at least one edge, until the frame position equals n.
  task automatic wait_cnt(input int n);
    int budget;
    budget = 4 * FRAME;
    do begin
      tick();
      budget--;
    end while (m_cnt != n && budget > 0);
    if (m_cnt != n) begin
      checks++;
      errors++;
      $display("FAIL wait_cnt position=%0d required=%0d", m_cnt, n);
    end
  endtask

  initial begin
    rst    = 1'b0;
    val_hi = 8'h00;
    val_lo = 8'h00;
    dp     = 4'h0;

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", 4'hF, 8'hFF);
    end
    @(negedge clk) rst = 1'b1;
    tick();
    chk("first_after_reset", 4'hE, 8'hC0);

    // Snapshot applied mid-frame 1; frame 1 stays zero.
    wait_cnt(8);
    @(negedge clk);
    val_hi = 8'h3A; val_lo = 8'h5F; dp = 4'b0100;
    wait_cnt(13);
    chk("frame1_digit3_old", 4'h7, 8'hC0);
    wait_cnt(1);
    chk("snap_digit0", 4'hE, 8'h8E);
    wait_cnt(5);
    chk("snap_digit1", 4'hD, 8'h92);
    wait_cnt(9);
    chk("snap_digit2_dp", 4'hB, 8'h08);
    wait_cnt(13);
    chk("snap_digit3", 4'h7, 8'hB0);

    // Tearing: lo changes mid-frame but shows only after the wrap.
    @(negedge clk);
    val_hi = 8'h00; val_lo = 8'h11; dp = 4'h0;
    wait_cnt(1);
    chk("tear_digit0_before", 4'hE, 8'hF9);
    wait_cnt(6);
    @(negedge clk);
    val_lo = 8'h22;
    wait_cnt(7);
    chk("tear_digit1_held", 4'hD, 8'hF9);
    wait_cnt(1);
    chk("tear_digit0_after", 4'hE, 8'hA4);
    wait_cnt(5);
    chk("tear_digit1_after", 4'hD, 8'hA4);

    // Reset mid-frame.
    wait_cnt(9);
    @(negedge clk) rst = 1'b0;
    tick();
    chk("midframe_reset", 4'hF, 8'hFF);
    @(negedge clk) rst = 1'b1;
    tick();
    chk("after_midframe_reset", 4'hE, 8'hC0);

    // Leading zeros.
    @(negedge clk);
    val_hi = 8'h07; val_lo = 8'h00; dp = 4'h0;
    wait_cnt(1);
    chk("lz_slot0", 4'hE, 8'hC0);
    wait_cnt(5);
`ifdef DISP_LZ_BLANK_EN
    chk("lz_slot1", 4'hF, 8'hFF);
`else
    chk("lz_slot1", 4'hD, 8'hC0);
`endif
    wait_cnt(9);
    chk("lz_slot2", 4'hB, 8'hF8);
    wait_cnt(13);
`ifdef DISP_LZ_BLANK_EN
    chk("lz_slot3", 4'hF, 8'hFF);
`else
    chk("lz_slot3", 4'h7, 8'hC0);
`endif

    // One more full frame purely against the model (anode walk).
    repeat (FRAME) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
